// File: rtl/pkg_elevador.sv
// Shared encodings for the elevator call manager.
// FSM states and travel directions.
package pkg_elevador;

  localparam logic [1:0] OCIOSO   = 2'b00;
  localparam logic [1:0] SUBINDO  = 2'b01;
  localparam logic [1:0] DESCENDO = 2'b10;
  localparam logic [1:0] PORTA    = 2'b11;

  localparam logic SOBE  = 1'b0;
  localparam logic DESCE = 1'b1;

endpackage

// File: rtl/seletor_direcao.sv
// Pending-request position relative to the cabin.
// Pure combinational; out-of-range floors give aqui=0.
module seletor_direcao #(
  parameter int NUM_ANDARES = 4,
  parameter int ANDAR_W     = $clog2(NUM_ANDARES)
) (
  input  logic [NUM_ANDARES-1:0] i_pendentes,
  input  logic [ANDAR_W-1:0]     i_andar_atual,
  output logic                   o_acima,
  output logic                   o_abaixo,
  output logic                   o_aqui
);

  logic [NUM_ANDARES-1:0] w_ge;
  logic [NUM_ANDARES-1:0] w_gt;

  // w_ge: floors >= current, w_gt: floors > current
  assign w_ge = {NUM_ANDARES{1'b1}} << i_andar_atual;
  assign w_gt = w_ge << 1;

  assign o_acima  = |(i_pendentes & w_gt);
  assign o_abaixo = |(i_pendentes & ~w_ge);
  assign o_aqui   = |(i_pendentes & w_ge & ~w_gt);

endmodule

// File: rtl/gerenciador_chamadas.sv
// Elevator call latch and SCAN cabin controller.
// Drives motor up/down and door-open levels.
module gerenciador_chamadas
  import pkg_elevador::*;
#(
  parameter int NUM_ANDARES = 4,
  parameter int ANDAR_W     = $clog2(NUM_ANDARES),
  parameter int TEMPO_PORTA = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ANDARES-1:0] pulso_chamada,
  input  logic [ANDAR_W-1:0]     andar_atual,
  input  logic                   chegou,
  output logic [NUM_ANDARES-1:0] pendentes,
  output logic                   motor_sobe,
  output logic                   motor_desce,
  output logic                   porta_aberta,
  output logic [1:0]             estado
);

  localparam int CW = (TEMPO_PORTA > 1) ? $clog2(TEMPO_PORTA) : 1;
  localparam logic [CW-1:0] CARGA = CW'(TEMPO_PORTA - 1);
  localparam logic [NUM_ANDARES-1:0] UM = NUM_ANDARES'(1);

  logic [1:0]             r_estado;
  logic                   r_dir;
  logic [CW-1:0]          r_cont;
  logic [NUM_ANDARES-1:0] r_pend;

  logic [1:0]             w_prox;
  logic                   w_dir_prox;
  logic [NUM_ANDARES-1:0] w_limpa;
  logic                   w_acima;
  logic                   w_abaixo;
  logic                   w_aqui;

  seletor_direcao #(
    .NUM_ANDARES(NUM_ANDARES),
    .ANDAR_W    (ANDAR_W)
  ) u_sel (
    .i_pendentes  (r_pend),
    .i_andar_atual(andar_atual),
    .o_acima      (w_acima),
    .o_abaixo     (w_abaixo),
    .o_aqui       (w_aqui)
  );

  // Clearing the served floor wins over a new press of it
  assign w_limpa = (r_estado == PORTA) ? (UM << andar_atual) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | pulso_chamada) & ~w_limpa;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_dir    <= SOBE;
      r_cont   <= '0;
    end else begin
      r_estado <= w_prox;
      r_dir    <= w_dir_prox;
      if (w_prox == PORTA && r_estado != PORTA) begin
        r_cont <= CARGA;
      end else if (r_estado == PORTA && r_cont != '0) begin
        r_cont <= r_cont - 1'b1;
      end
    end
  end

  always_comb begin
    w_prox     = r_estado;
    w_dir_prox = r_dir;
    unique case (r_estado)
      OCIOSO: begin
        if (w_aqui) begin
          w_prox = PORTA;
        end else if (w_acima) begin
          w_prox     = SUBINDO;
          w_dir_prox = SOBE;
        end else if (w_abaixo) begin
          w_prox     = DESCENDO;
          w_dir_prox = DESCE;
        end
      end
      SUBINDO: begin
        if (chegou) begin
          if (w_aqui) begin
            w_prox = PORTA;
          end else if (w_acima) begin
            w_prox = SUBINDO;
          end else if (w_abaixo) begin
            w_prox     = DESCENDO;
            w_dir_prox = DESCE;
          end else begin
            w_prox = OCIOSO;
          end
        end
      end
      DESCENDO: begin
        if (chegou) begin
          if (w_aqui) begin
            w_prox = PORTA;
          end else if (w_abaixo) begin
            w_prox = DESCENDO;
          end else if (w_acima) begin
            w_prox     = SUBINDO;
            w_dir_prox = SOBE;
          end else begin
            w_prox = OCIOSO;
          end
        end
      end
      PORTA: begin
        if (r_cont == '0) begin
          if (r_dir == SOBE && w_acima) begin
            w_prox = SUBINDO;
          end else if (r_dir == DESCE && w_abaixo) begin
            w_prox = DESCENDO;
          end else if (w_acima) begin
            w_prox     = SUBINDO;
            w_dir_prox = SOBE;
          end else if (w_abaixo) begin
            w_prox     = DESCENDO;
            w_dir_prox = DESCE;
          end else begin
            w_prox = OCIOSO;
          end
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_comb begin
    motor_sobe   = (r_estado == SUBINDO);
    motor_desce  = (r_estado == DESCENDO);
    porta_aberta = (r_estado == PORTA);
  end

  assign pendentes = r_pend;
  assign estado    = r_estado;

endmodule
